// File: rtl/aes_cbc_en.sv
// AES CBC-mode encryptor: combinational aes_en core plus chaining front end.
// Ports: clk/rst, start+key+iv, in_* plaintext stream, out_* ciphertext, busy.

// aes_en: purely combinational AES block encryption.
// Ports: text (plaintext), key (LEN_KEY bits), cipher (ciphertext).
// Byte 0 of every 128-bit block sits in [127:120].
module aes_en #(
    parameter int LEN_KEY   = 128,
    parameter int NUM_ROUND = 10
) (
    input  logic [127:0]         text,
    input  logic [LEN_KEY-1:0]   key,
    output logic [127:0]         cipher
);

    localparam int NK = LEN_KEY / 32;
    localparam int NW = 4 * (NUM_ROUND + 1);

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(
        input logic [7:0] a,
        input logic [7:0] b
    );
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // S-box computed rather than tabled: inverse is a^254
    // (a^2 * a^4 * ... * a^128), which also maps 0 to 0.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] b;
        p = a;
        b = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            b = gf_mul(b, p);
        end
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]}
                 ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]),
                sbox(w[15:8]),  sbox(w[7:0])};
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] r;
        for (int i = 0; i < 16; i++)
            r[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
        return r;
    endfunction

    // State is column-major: byte index = row + 4*col.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] r;
        for (int row = 0; row < 4; row++)
            for (int col = 0; col < 4; col++)
                r[127-8*(row+4*col) -: 8] =
                    s[127-8*(row+4*((col+row)%4)) -: 8];
        return r;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            r[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            r[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            r[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            r[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return r;
    endfunction

    function automatic logic [127:0] encrypt(
        input logic [127:0]       pt,
        input logic [LEN_KEY-1:0] k
    );
        logic [31:0]  w [NW];
        logic [31:0]  t;
        logic [7:0]   rc;
        logic [127:0] st;
        rc = 8'h01;
        for (int i = 0; i < NK; i++)
            w[i] = k[LEN_KEY-1-32*i -: 32];
        for (int i = NK; i < NW; i++) begin
            t = w[i-1];
            if (i % NK == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xtime(rc);
            end else if (NK > 6 && i % NK == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-NK] ^ t;
        end
        st = pt ^ {w[0], w[1], w[2], w[3]};
        for (int r = 1; r <= NUM_ROUND; r++) begin
            st = shift_rows(sub_bytes(st));
            if (r != NUM_ROUND) st = mix_columns(st);
            st = st ^ {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        end
        return st;
    endfunction

    assign cipher = encrypt(text, key);

endmodule

module aes_cbc_en #(
    parameter int LEN_KEY   = 128,
    parameter int NUM_ROUND = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [LEN_KEY-1:0]   key,
    input  logic [127:0]         iv,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [127:0]         in_data,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [127:0]         out_data,
    output logic                 out_last,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCEPT = 2'd1,
        CALC   = 2'd2,
        OUTPUT = 2'd3
    } state_t;

    state_t               state;
    state_t               state_n;
    logic [LEN_KEY-1:0]   key_r;
    logic [127:0]         chain;
    logic [127:0]         blk_r;
    logic                 last_r;
    logic [127:0]         core_out;

    // Core sits between blk_r and out_data: one full cycle of logic.
    aes_en #(
        .LEN_KEY   (LEN_KEY),
        .NUM_ROUND (NUM_ROUND)
    ) u_core (
        .text   (blk_r),
        .key    (key_r),
        .cipher (core_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            key_r    <= '0;
            chain    <= '0;
            blk_r    <= '0;
            last_r   <= 1'b0;
            out_data <= '0;
            out_last <= 1'b0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: begin
                    if (start) begin
                        key_r <= key;
                        chain <= iv;
                    end
                end
                ACCEPT: begin
                    if (in_valid) begin
                        blk_r  <= in_data ^ chain;
                        last_r <= in_last;
                    end
                end
                CALC: begin
                    // Ciphertext doubles as the next chaining value.
                    out_data <= core_out;
                    chain    <= core_out;
                    out_last <= last_r;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_n   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                if (start) state_n = ACCEPT;
            end
            ACCEPT: begin
                in_ready = 1'b1;
                if (in_valid) state_n = CALC;
            end
            CALC: begin
                state_n = OUTPUT;
            end
            OUTPUT: begin
                out_valid = 1'b1;
                if (out_ready) state_n = out_last ? IDLE : ACCEPT;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_aes_cbc_en.sv
// Self-checking bench for aes_cbc_en using FIPS-197 / SP800-38A vectors.
// Scoreboard queue holds {last, ciphertext} pushed at send time.
module tb_aes_cbc_en;

    localparam logic [127:0] FK  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FP  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FC  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CK  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CIV = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1  = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] C1  = 128'h7649abac8119b246cee98e9b12e9197d;
    localparam logic [127:0] P2  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [127:0] C2  = 128'h5086cb9b507219ee95db113a917678b2;
    localparam logic [127:0] JK  = 128'hdeadbeefcafef00d0123456789abcdef;
    localparam logic [127:0] JIV = 128'hffeeddccbbaa99887766554433221100;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] key;
    logic [127:0] iv;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         out_last;
    logic         busy;

    int passed = 0;
    int total  = 0;
    logic [128:0] sb[$];

    always #5 clk = ~clk;

    aes_cbc_en dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .key       (key),
        .iv        (iv),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    task automatic start_msg(input logic [127:0] k, input logic [127:0] v);
        start = 1'b1;
        key   = k;
        iv    = v;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(
        input  logic [127:0] d,
        input  logic         l,
        input  bit           poke,
        output bit           ok
    );
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (in_ready) ok = 1'b1;
            else @(negedge clk);
        end
        if (!ok) return;
        if (poke) begin
            start = 1'b1;
            key   = JK;
            iv    = JIV;
            @(negedge clk);
            start = 1'b0;
        end
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic recv(
        input  int           stall,
        input  bit           poke,
        output logic [127:0] d,
        output logic         l,
        output bit           got,
        output bit           stable
    );
        got    = 1'b0;
        stable = 1'b1;
        d      = '0;
        l      = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            if (out_valid) got = 1'b1;
            else @(negedge clk);
        end
        if (!got) return;
        d = out_data;
        l = out_last;
        for (int i = 0; i < stall; i++) begin
            if (poke && i == 0) begin
                start = 1'b1;
                key   = JK;
                iv    = JIV;
            end
            @(negedge clk);
            start = 1'b0;
            if (out_data !== d || out_last !== l ||
                out_valid !== 1'b1 || in_ready !== 1'b0)
                stable = 1'b0;
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        logic [131:0] obs;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        obs = {in_ready, out_valid, out_last, busy, out_data};
        total++;
        if (obs !== 132'h0)
            $display("FAIL reset_outputs got %h want 0", obs);
        else passed++;
        rst = 1'b0;
        @(negedge clk);
        obs = {in_ready, out_valid, out_last, busy, out_data};
        total++;
        if (obs !== 132'h0)
            $display("FAIL reset_idle got %h want 0", obs);
        else passed++;
    endtask

    task automatic test_fips(input string nm);
        bit           ok;
        bit           got;
        bit           st;
        logic [127:0] d;
        logic         l;
        logic [128:0] exp;
        start_msg(FK, 128'h0);
        total++;
        if ({busy, in_ready} !== 2'b11)
            $display("FAIL %s_accept got %b want 11", nm, {busy, in_ready});
        else passed++;
        sb.push_back({1'b1, FC});
        send(FP, 1'b1, 1'b0, ok);
        total++;
        if (!ok) $display("FAIL %s_send timeout got 0 want 1", nm);
        else passed++;
        total++;
        if ({out_valid, in_ready} !== 2'b00)
            $display("FAIL %s_calc got %b want 00", nm, {out_valid, in_ready});
        else passed++;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b1)
            $display("FAIL %s_latency got %b want 1", nm, out_valid);
        else passed++;
        recv(0, 1'b0, d, l, got, st);
        exp = sb.pop_front();
        total++;
        if (!got || {l, d} !== exp)
            $display("FAIL %s_data got %b %h want %h", nm, got, {l, d}, exp);
        else passed++;
        total++;
        if (busy !== 1'b0)
            $display("FAIL %s_idle busy got %b want 0", nm, busy);
        else passed++;
    endtask

    task automatic test_cbc(input string nm, input int stall, input bit poke);
        bit           ok;
        bit           got;
        bit           st;
        logic [127:0] d;
        logic         l;
        logic [128:0] exp;
        logic [127:0] pt [2];
        pt[0] = P1;
        pt[1] = P2;
        start_msg(CK, CIV);
        sb.push_back({1'b0, C1});
        sb.push_back({1'b1, C2});
        for (int b = 0; b < 2; b++) begin
            send(pt[b], b == 1, poke, ok);
            total++;
            if (!ok) $display("FAIL %s_send%0d timeout got 0 want 1", nm, b);
            else passed++;
            recv(stall, poke, d, l, got, st);
            exp = sb.pop_front();
            total++;
            if (!got || {l, d} !== exp)
                $display("FAIL %s_c%0d got %b %h want %h",
                         nm, b + 1, got, {l, d}, exp);
            else passed++;
            if (stall > 0) begin
                total++;
                if (!st)
                    $display("FAIL %s_stable%0d got 0 want 1", nm, b);
                else passed++;
            end
        end
        total++;
        if (busy !== 1'b0)
            $display("FAIL %s_idle busy got %b want 0", nm, busy);
        else passed++;
    endtask

    task automatic test_reset_mid();
        bit           ok;
        logic [130:0] obs;
        bit           seen;
        start_msg(CK, CIV);
        send(P1, 1'b0, 1'b0, ok);
        total++;
        if (!ok) $display("FAIL rstmid_send timeout got 0 want 1");
        else passed++;
        rst = 1'b1;
        @(negedge clk);
        obs = {out_valid, in_ready, busy, out_data};
        rst = 1'b0;
        total++;
        if (obs !== 131'h0)
            $display("FAIL rstmid_state got %h want 0", obs);
        else passed++;
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid || busy) seen = 1'b1;
        end
        total++;
        if (seen)
            $display("FAIL rstmid_quiet got 1 want 0");
        else passed++;
        test_fips("rstmid_fips");
    endtask

    task automatic test_back_to_back();
        test_cbc("b2b_cbc", 0, 1'b0);
        test_fips("b2b_fips");
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        key       = '0;
        iv        = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_fips("fips");
        test_cbc("cbc2", 0, 1'b0);
        test_cbc("backpressure", 5, 1'b0);
        test_cbc("ignored_start", 2, 1'b1);
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
